// File: rtl/antirrebote_entradas.sv
// antirrebote_entradas: two-channel push-button conditioner.
// Each raw button line is synchronized through two flops and debounced by a
// small per-channel FSM. The debounced level only moves after the synchronized
// input has disagreed with it for CUENTA_ESTABLE consecutive cycles.
// Salida feeds the downstream AND stage directly. Cambio is a one-cycle pulse
// in the cycle Salida takes a new value.
module antirrebote_entradas #(
  parameter int unsigned CUENTA_ESTABLE = 16
) (
  input  logic       Reloj,
  input  logic       Reset_n,
  input  logic [1:0] Boton,
  output logic [1:0] Salida,
  output logic [1:0] Cambio
);

  localparam int unsigned NUM_CANALES = 2;
  localparam int unsigned CW          = $clog2(CUENTA_ESTABLE);

  // The terminal count is one less than the stability window. The ESTABLE->
  // VERIFICANDO transition loads 1, so the level moves on the
  // CUENTA_ESTABLE-th consecutive disagreeing sample.
  localparam logic [CW-1:0] CNT_FIN = CW'(CUENTA_ESTABLE - 1);
  localparam logic [CW-1:0] CNT_UNO = CW'(1);
  localparam logic [CW-1:0] CNT_CERO = '0;

  typedef enum logic {
    ESTABLE     = 1'b0,
    VERIFICANDO = 1'b1
  } estado_t;

  for (genvar i = 0; i < NUM_CANALES; i++) begin : gen_canal

    logic    s1_q, s1_d;
    logic    s2_q, s2_d;
    estado_t estado_q, estado_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic    salida_q, salida_d;
    logic    cambio_q, cambio_d;

    logic    difiere;
    logic    cuenta_llena;

    // Two-flop synchronizer. Only s2 is looked at by the debounce logic.
    always_comb begin
      s1_d = Boton[i];
      s2_d = s1_q;
    end

    // Qualification conditions shared by next-state and output logic.
    always_comb begin
      difiere      = (s2_q != salida_q);
      cuenta_llena = (cnt_q == CNT_FIN);
    end

    // State register plus all channel flops. The reset is asynchronous.
    always_ff @(posedge Reloj or negedge Reset_n) begin
      if (!Reset_n) begin
        s1_q     <= 1'b0;
        s2_q     <= 1'b0;
        estado_q <= ESTABLE;
        cnt_q    <= CNT_CERO;
        salida_q <= 1'b0;
        cambio_q <= 1'b0;
      end else begin
        s1_q     <= s1_d;
        s2_q     <= s2_d;
        estado_q <= estado_d;
        cnt_q    <= cnt_d;
        salida_q <= salida_d;
        cambio_q <= cambio_d;
      end
    end

    // Next-state logic. Any agreeing sample while verifying counts as a glitch.
    always_comb begin
      estado_d = estado_q;
      unique case (estado_q)
        ESTABLE: begin
          if (difiere) begin
            estado_d = VERIFICANDO;
          end
        end
        VERIFICANDO: begin
          if (!difiere || cuenta_llena) begin
            estado_d = ESTABLE;
          end
        end
        default: estado_d = ESTABLE;
      endcase
    end

    // Output and counter logic. The counter is cleared before it could wrap.
    always_comb begin
      cnt_d    = cnt_q;
      salida_d = salida_q;
      cambio_d = 1'b0;
      unique case (estado_q)
        ESTABLE: begin
          cnt_d = difiere ? CNT_UNO : CNT_CERO;
        end
        VERIFICANDO: begin
          if (!difiere) begin
            cnt_d = CNT_CERO;
          end else if (cuenta_llena) begin
            salida_d = s2_q;
            cambio_d = 1'b1;
            cnt_d    = CNT_CERO;
          end else begin
            cnt_d = cnt_q + CNT_UNO;
          end
        end
        default: begin
          cnt_d = CNT_CERO;
        end
      endcase
    end

    // Registered outputs go straight to the ports.
    assign Salida[i] = salida_q;
    assign Cambio[i] = cambio_q;

  end : gen_canal

endmodule
